// File: rtl/calc_pkg.sv
// Shared types and sizing for the calculator keypad number builder.
package calc_pkg;

    localparam int NUM_W      = 22;
    localparam int MAX_DIGITS = 6;
    localparam int LEN_W      = 3;

    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } entry_state_t;

    function automatic logic is_decimal(input bcd_t d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational decimal shift-in step: result = acc*10 + d using shifts only.
module mul10_add
    import calc_pkg::*;
(
    input  logic [NUM_W-1:0] acc,
    input  bcd_t             d,
    output logic [NUM_W-1:0] result
);

    assign result = (acc << 3) + (acc << 1) + {{(NUM_W-4){1'b0}}, d};

endmodule

// File: rtl/digit_entry.sv
// Keypad digit buffer with serial BCD-to-binary conversion and sign handling.
// Optional build macro DIGIT_ENTRY_ZERO_SUPPRESS_EN discards leading zero keys.
module digit_entry
    import calc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic                    bksp,
    input  logic                    clear,
    input  logic                    negate,
    output logic                    ready,
    output logic signed [NUM_W-1:0] binary_num,
    output logic [LEN_W-1:0]        length,
    output logic                    value_valid,
    output logic                    overflow
);

    entry_state_t     state_r, state_s;
    logic [LEN_W-1:0] len_r, len_s;
    logic [LEN_W-1:0] idx_r, idx_s;
    logic             sign_r, sign_s;
    bcd_t             digits_r [MAX_DIGITS];
    bcd_t             digits_s [MAX_DIGITS];
    logic [NUM_W-1:0] acc_r, acc_s;
    logic [NUM_W-1:0] num_r, num_s;
    logic             vv_r, vv_s;
    logic             ovf_r, ovf_s;
    bcd_t             cur_digit_s;
    logic [NUM_W-1:0] mac_s;
    logic             last_s;
    logic             zero_drop_s;

    // An empty buffer converts as a single zero digit.
    assign cur_digit_s = (len_r == {LEN_W{1'b0}}) ? 4'd0 : digits_r[idx_r];
    assign last_s      = (len_r == {LEN_W{1'b0}}) || (idx_r == (len_r - LEN_W'(1)));

`ifdef DIGIT_ENTRY_ZERO_SUPPRESS_EN
    assign zero_drop_s = (digit == 4'd0) && (len_r == {LEN_W{1'b0}});
`else
    assign zero_drop_s = 1'b0;
`endif

    mul10_add u_mul10_add (
        .acc    (acc_r),
        .d      (cur_digit_s),
        .result (mac_s)
    );

    // Next-state, buffer edits and conversion step.
    always_comb begin
        state_s   = state_r;
        len_s     = len_r;
        idx_s     = idx_r;
        sign_s    = sign_r;
        digits_s  = digits_r;
        acc_s     = acc_r;
        num_s     = num_r;
        vv_s      = 1'b0;
        ovf_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_s = {LEN_W{1'b0}};
                acc_s = {NUM_W{1'b0}};
                if (clear) begin
                    len_s   = {LEN_W{1'b0}};
                    sign_s  = 1'b0;
                    state_s = ST_CONVERT;
                end else if (bksp) begin
                    if (len_r != {LEN_W{1'b0}}) begin
                        len_s   = len_r - LEN_W'(1);
                        state_s = ST_CONVERT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (negate) begin
                    sign_s  = ~sign_r;
                    state_s = ST_CONVERT;
                end else if (digit_valid && is_decimal(digit)) begin
                    if (len_r == LEN_W'(MAX_DIGITS)) begin
                        ovf_s = 1'b1;
                    end else if (zero_drop_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        digits_s[len_r] = digit;
                        len_s           = len_r + LEN_W'(1);
                        state_s         = ST_CONVERT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                acc_s = mac_s;
                idx_s = idx_r + LEN_W'(1);
                // Two's-complement negate; a zero magnitude stays zero.
                if (last_s) begin
                    num_s   = sign_r ? (~mac_s + NUM_W'(1)) : mac_s;
                    vv_s    = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CONVERT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            len_r   <= {LEN_W{1'b0}};
            idx_r   <= {LEN_W{1'b0}};
            sign_r  <= 1'b0;
            acc_r   <= {NUM_W{1'b0}};
            num_r   <= {NUM_W{1'b0}};
            vv_r    <= 1'b0;
            ovf_r   <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits_r[i] <= 4'd0;
            end
        end else begin
            state_r  <= state_s;
            len_r    <= len_s;
            idx_r    <= idx_s;
            sign_r   <= sign_s;
            acc_r    <= acc_s;
            num_r    <= num_s;
            vv_r     <= vv_s;
            ovf_r    <= ovf_s;
            digits_r <= digits_s;
        end
    end

    assign ready       = (state_r == ST_IDLE);
    assign binary_num  = num_r;
    assign length      = len_r;
    assign value_valid = vv_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry against a queue-based keypad model.
module tb_digit_entry;
    import calc_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    digit_valid = 1'b0;
    logic [3:0]              digit = 4'd0;
    logic                    bksp = 1'b0;
    logic                    clear = 1'b0;
    logic                    negate = 1'b0;
    logic                    ready;
    logic signed [NUM_W-1:0] binary_num;
    logic [LEN_W-1:0]        length;
    logic                    value_valid;
    logic                    overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int               model_q[$];
    bit               model_sign = 1'b0;
    logic [NUM_W-1:0] model_num = '0;

    digit_entry dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .bksp        (bksp),
        .clear       (clear),
        .negate      (negate),
        .ready       (ready),
        .binary_num  (binary_num),
        .length      (length),
        .value_valid (value_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_W-1:0] model_value();
        int v = 0;
        foreach (model_q[i]) v = v * 10 + model_q[i];
        if (model_sign) v = -v;
        return NUM_W'(v);
    endfunction

    task automatic drop_inputs();
        digit_valid = 1'b0; digit = 4'd0; bksp = 1'b0; clear = 1'b0; negate = 1'b0;
    endtask

    // Issue one command, update the model, and check the full response window.
    task automatic send(input bit clr, input bit bk, input bit neg, input bit dv,
                        input logic [3:0] d, input bit poke);
        bit conv = 1'b0;
        bit ovf  = 1'b0;
        int lat;
        int t = 0;
        while (!ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!ready) begin
            n_fail++;
            $display("FAIL ready_timeout: ready=%b required 1", ready);
        end
        if (clr) begin
            model_q.delete(); model_sign = 1'b0; conv = 1'b1;
        end else if (bk) begin
            if (model_q.size() > 0) begin
                void'(model_q.pop_back()); conv = 1'b1;
            end
        end else if (neg) begin
            model_sign = ~model_sign; conv = 1'b1;
        end else if (dv && d <= 4'd9) begin
            if (model_q.size() == MAX_DIGITS) ovf = 1'b1;
`ifdef DIGIT_ENTRY_ZERO_SUPPRESS_EN
            else if (d == 4'd0 && model_q.size() == 0) conv = 1'b0;
`endif
            else begin
                model_q.push_back(int'(d)); conv = 1'b1;
            end
        end
        clear = clr; bksp = bk; negate = neg; digit_valid = dv; digit = d;
        @(posedge clk);
        @(negedge clk);
        drop_inputs();
        n_checks++;
        if (length !== LEN_W'(model_q.size())) begin
            n_fail++;
            $display("FAIL length: got %0d required %0d", length, model_q.size());
        end
        if (conv) begin
            lat = (model_q.size() > 1) ? model_q.size() : 1;
            model_num = model_value();
            for (int j = 0; j <= lat; j++) begin
                n_checks++;
                if (value_valid !== (j == lat) || ready !== (j == lat)) begin
                    n_fail++;
                    $display("FAIL conv_timing j=%0d: value_valid=%b ready=%b required %b", j, value_valid, ready, (j == lat));
                end
                if (j == lat) begin
                    n_checks++;
                    if (binary_num !== model_num) begin
                        n_fail++;
                        $display("FAIL binary_num: got %h required %h", binary_num, model_num);
                    end
                end
                if (poke && j == 0) begin
                    digit_valid = 1'b1; digit = 4'd3; negate = 1'b1; bksp = 1'b1; clear = 1'b1;
                end
                if (j < lat) begin
                    @(negedge clk);
                    drop_inputs();
                end
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (value_valid !== 1'b0 || overflow !== (ovf && j == 0) || ready !== 1'b1
                    || binary_num !== model_num) begin
                    n_fail++;
                    $display("FAIL no_conv j=%0d: vv=%b ovf=%b ready=%b num=%h required 0/%b/1/%h",
                             j, value_valid, overflow, ready, binary_num, (ovf && j == 0), model_num);
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (binary_num !== '0 || length !== '0 || value_valid !== 1'b0 || overflow !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: num=%h len=%0d vv=%b ovf=%b ready=%b required 0/0/0/0/1",
                     binary_num, length, value_valid, overflow, ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_digits();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
    endtask

    task automatic test_negate();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        n_checks++;
        if (binary_num !== 22'h3FFFD3) begin
            n_fail++;
            $display("FAIL minus45: got %h required 3fffd3", binary_num);
        end
        send(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_overflow();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
        n_checks++;
        if (binary_num !== 22'd999999 || length !== 3'd6) begin
            n_fail++;
            $display("FAIL full_value: num=%0d len=%0d required 999999/6", binary_num, length);
        end
    endtask

    task automatic test_bksp_clear();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    endtask

    task automatic test_priority();
        send(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
    endtask

    task automatic test_leading_zero();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    endtask

    task automatic test_reset_mid_convert();
        send(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 5; i++) send(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
        negate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_inputs();
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_before_rst: ready=%b required 0", ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (binary_num !== '0 || length !== '0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: num=%h len=%0d ready=%b required 0/0/1", binary_num, length, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_q.delete(); model_sign = 1'b0; model_num = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_checks++;
            if (value_valid !== 1'b0 || ready !== 1'b1 || binary_num !== '0 || length !== '0) begin
                n_fail++;
                $display("FAIL after_rst j=%0d: vv=%b ready=%b num=%h len=%0d required 0/1/0/0",
                         j, value_valid, ready, binary_num, length);
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] d;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            send(r < 4, (r < 22) && (r >= 4 || $urandom_range(0, 1) == 1), (r >= 22 && r < 32),
                 (r >= 32) || ($urandom_range(0, 3) == 0), d, $urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_negate();
        test_overflow();
        test_bksp_clear();
        test_priority();
        test_leading_zero();
        test_reset_mid_convert();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_entry.md
Name: digit_entry

Overview:
- Keypad-side number builder for the calculator; it performs the inverse of the digit-length/display path.
- Accepts decimal digit keystrokes plus backspace, clear and negate commands, and holds up to 6 entered digits.
- Converts the held digits to a signed 22-bit two's-complement operand for the ALU.
- Also reports the entered digit count, so display logic needs no reconversion.

Parameters:
- NUM_W, 22, width of the signed binary result.
- MAX_DIGITS, 6, maximum decimal digits held (999999 < 2^21, so no wrap).
- LEN_W, 3, width of the length output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit_valid  in  1  digit keystroke strobe, one cycle per key.
- digit  in  4  BCD digit; values 10..15 are ignored.
- bksp  in  1  remove the most recently entered digit.
- clear  in  1  empty the buffer and clear the sign.
- negate  in  1  toggle the sign flag.
- ready  out  1  high in IDLE; commands accepted only when high.
- binary_num  out  NUM_W (signed)  converted operand.
- length  out  LEN_W  count of entered digits, 0..6.
- value_valid  out  1  one-cycle pulse when binary_num is updated.
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full.

Behaviour:
- Reset (async, any state): buffer cleared, length=0, sign=0, binary_num=0, value_valid=0, overflow=0. State goes to IDLE, so ready=1 from the first edge after rst deasserts. Reset during CONVERT abandons the conversion; no value_valid pulse.
- FSM states: IDLE, CONVERT.
- IDLE: at most one command is accepted per cycle. Priority is clear > bksp > negate > digit_valid; lower-priority simultaneous commands are dropped.
  - clear: buffer emptied, length=0, sign=0 → CONVERT.
  - bksp with length>0: newest digit discarded, length-1 → CONVERT. With length=0: no-op, stay IDLE, no pulse.
  - negate: sign toggles → CONVERT.
  - digit_valid, digit<=9, length<MAX_DIGITS: digit pushed as newest, length+1 → CONVERT.
  - digit_valid, length==MAX_DIGITS: buffer unchanged; overflow pulses the next cycle; stay IDLE.
  - digit_valid, digit>9: ignored entirely.
- Leading zeros are stored and counted by default (see Optional Feature).
- CONVERT: ready=0; all command inputs are ignored, not queued.
  - Accumulator starts at 0 and processes the oldest digit first, one digit per cycle: acc = acc*10 + d. Runs max(length,1) cycles; length=0 yields acc=0 in one cycle.
  - On the final cycle edge: binary_num = sign ? -acc : acc; value_valid=1 for one cycle; return to IDLE.
  - Negative zero is forced to 0, but the sign flag is retained.
- Latency: command accepted on edge N → value_valid high in the cycle after edge N+max(L,1), where L is the new length. Maximum is 7 cycles.
- binary_num and length hold their values between updates. length updates on the accept edge; binary_num updates only at conversion end.
- Arithmetic: acc is NUM_W unsigned internally; maximum 999999 never overflows. Negation is two's complement on NUM_W bits.

Optional Feature:
- Macro DIGIT_ENTRY_ZERO_SUPPRESS_EN.
- When defined: a digit 0 received with length==0 is discarded. Stay IDLE, no conversion, no pulse, length stays 0.
- When undefined: a leading 0 is stored and counted, and a conversion runs normally (value unchanged, length increments).

Decomposition:
- Package calc_pkg holds NUM_W, MAX_DIGITS, LEN_W, the bcd_t 4-bit typedef, and the FSM state enum.
- One sub-module, mul10_add: combinational acc*10+d computed as (acc<<3)+(acc<<1)+d, width NUM_W.
- Buffer and FSM live in digit_entry.

Test Plan:
- Digits 1,2,3 spaced by idle gaps → three value_valid pulses with binary_num 1, 12, 123. Final length=3. Pulse 4 cycles after the third key.
- Enter 4,5 then negate → binary_num=-45 (22'h3FFFD3). Negate again → 45.
- Enter 9 six times then digit 7 → binary_num=999999, length=6. Overflow pulses once and the value is unchanged.
- Enter 8,6,bksp → 86 then 8, length=1. bksp twice more → 0, then no-op with no pulse on the second. clear with sign set → 0, sign cleared.
- Assert clear, bksp and digit_valid in the same cycle → clear wins. Keystroke during CONVERT → ignored; ready=0 observed.
- Assert rst mid-CONVERT of a 5-digit value → outputs 0, no value_valid, ready=1 after release.
- With macro: key 0 then 5 → length=1, value 5. Without macro: length=2, value 5.
